// File: rtl/mips_cu_pkg.sv
// Encodings shared by the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operations and the datapath select codes.
package mips_cu_pkg;

  localparam int STATE_W = 4;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_ADDI_EX  = 4'd8;
  localparam logic [3:0] S_ADDI_WB  = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_BNE      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic SRCA_PC     = 1'b0;
  localparam logic SRCA_REG    = 1'b1;
  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;
  localparam logic WD_ALUOUT   = 1'b0;
  localparam logic WD_MEM      = 1'b1;
  localparam logic WR_RT       = 1'b0;
  localparam logic WR_RD       = 1'b1;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational R-type funct decoder: selects the ALU operation and flags
// whether the funct field is one the datapath supports.
module alu_decoder
  import mips_cu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_valid
);

  // funct -> ALU operation lookup
  always_comb begin
    alu_op      = ALU_AND;
    funct_valid = 1'b0;
    case (funct)
      FN_ADD: begin alu_op = ALU_ADD; funct_valid = 1'b1; end
      FN_SUB: begin alu_op = ALU_SUB; funct_valid = 1'b1; end
      FN_AND: begin alu_op = ALU_AND; funct_valid = 1'b1; end
      FN_OR:  begin alu_op = ALU_OR;  funct_valid = 1'b1; end
      FN_SLT: begin alu_op = ALU_SLT; funct_valid = 1'b1; end
      default: begin alu_op = ALU_AND; funct_valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath (FETCH..WRITEBACK).
// Define CU_BNE_EN to add bne (opcode 000101) support.
module multicycle_control_unit
  import mips_cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       enable_PC,
  output logic       Selector_Addr,
  output logic       enable_MemSys,
  output logic       enable_RegIns,
  output logic       enable_RF,
  output logic       Selector_RF_WR,
  output logic       Selector_RF_WD,
  output logic       Selector_ALU_Src_A,
  output logic [1:0] Selector_ALU_Src_B,
  output logic [2:0] Selector_ALU_Op,
  output logic [1:0] Selector_PC_Source,
  output logic       illegal_op
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] next_state_s;
  logic [2:0]         funct_op_s;
  logic               funct_valid_s;
  logic               decode_illegal_s;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_op      (funct_op_s),
    .funct_valid (funct_valid_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; decode_illegal_s flags opcodes/functs with no execution path
  always_comb begin
    next_state_s     = S_FETCH;
    decode_illegal_s = 1'b0;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct_valid_s) begin
              next_state_s = S_RTYPE_EX;
            end else begin
              decode_illegal_s = 1'b1;
            end
          end
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_ADDI:      next_state_s = S_ADDI_EX;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_J:         next_state_s = S_JUMP;
`ifdef CU_BNE_EN
          OP_BNE:       next_state_s = S_BNE;
`endif
          default:      decode_illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD:    next_state_s = S_MEMWB;
      S_RTYPE_EX: next_state_s = S_RTYPE_WB;
      S_ADDI_EX:  next_state_s = S_ADDI_WB;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Moore output decode, forced inactive while reset is asserted
  always_comb begin
    enable_PC          = 1'b0;
    Selector_Addr      = ADDR_PC;
    enable_MemSys      = 1'b0;
    enable_RegIns      = 1'b0;
    enable_RF          = 1'b0;
    Selector_RF_WR     = WR_RT;
    Selector_RF_WD     = WD_ALUOUT;
    Selector_ALU_Src_A = SRCA_PC;
    Selector_ALU_Src_B = SRCB_REG;
    Selector_ALU_Op    = ALU_AND;
    Selector_PC_Source = PCSRC_ALU;
    illegal_op         = 1'b0;
    if (reset) begin
      illegal_op = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          enable_RegIns      = 1'b1;
          enable_PC          = 1'b1;
          Selector_ALU_Src_B = SRCB_FOUR;
          Selector_ALU_Op    = ALU_ADD;
        end
        S_DECODE: begin
          Selector_ALU_Src_B = SRCB_IMM_SH;
          Selector_ALU_Op    = ALU_ADD;
          illegal_op         = decode_illegal_s;
        end
        S_MEMADR, S_ADDI_EX: begin
          Selector_ALU_Src_A = SRCA_REG;
          Selector_ALU_Src_B = SRCB_IMM;
          Selector_ALU_Op    = ALU_ADD;
        end
        S_MEMRD: Selector_Addr = ADDR_ALUOUT;
        S_MEMWB: begin
          enable_RF      = 1'b1;
          Selector_RF_WR = WR_RT;
          Selector_RF_WD = WD_MEM;
        end
        S_MEMWR: begin
          Selector_Addr = ADDR_ALUOUT;
          enable_MemSys = 1'b1;
        end
        S_RTYPE_EX: begin
          Selector_ALU_Src_A = SRCA_REG;
          Selector_ALU_Src_B = SRCB_REG;
          Selector_ALU_Op    = funct_op_s;
        end
        S_RTYPE_WB: begin
          enable_RF      = 1'b1;
          Selector_RF_WR = WR_RD;
          Selector_RF_WD = WD_ALUOUT;
        end
        S_ADDI_WB: begin
          enable_RF      = 1'b1;
          Selector_RF_WR = WR_RT;
          Selector_RF_WD = WD_ALUOUT;
        end
        S_BRANCH: begin
          Selector_ALU_Src_A = SRCA_REG;
          Selector_ALU_Src_B = SRCB_REG;
          Selector_ALU_Op    = ALU_SUB;
          Selector_PC_Source = PCSRC_ALUOUT;
          enable_PC          = zero;
        end
`ifdef CU_BNE_EN
        S_BNE: begin
          Selector_ALU_Src_A = SRCA_REG;
          Selector_ALU_Src_B = SRCB_REG;
          Selector_ALU_Op    = ALU_SUB;
          Selector_PC_Source = PCSRC_ALUOUT;
          enable_PC          = ~zero;
        end
`endif
        S_JUMP: begin
          Selector_PC_Source = PCSRC_JUMP;
          enable_PC          = 1'b1;
        end
        default: illegal_op = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// cycle by cycle and compares the full output bundle against hand-built vectors.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF;
  logic       Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, illegal_op;
  logic [1:0] Selector_ALU_Src_B, Selector_PC_Source;
  logic [2:0] Selector_ALU_Op;

  int checks;
  int errors;

  multicycle_control_unit dut (
    .clk                (clk),
    .reset              (reset),
    .opcode             (opcode),
    .funct              (funct),
    .zero               (zero),
    .enable_PC          (enable_PC),
    .Selector_Addr      (Selector_Addr),
    .enable_MemSys      (enable_MemSys),
    .enable_RegIns      (enable_RegIns),
    .enable_RF          (enable_RF),
    .Selector_RF_WR     (Selector_RF_WR),
    .Selector_RF_WD     (Selector_RF_WD),
    .Selector_ALU_Src_A (Selector_ALU_Src_A),
    .Selector_ALU_Src_B (Selector_ALU_Src_B),
    .Selector_ALU_Op    (Selector_ALU_Op),
    .Selector_PC_Source (Selector_PC_Source),
    .illegal_op         (illegal_op)
  );

  // Bundle order: PC, Addr, MemSys, RegIns, RF, WR, WD, SrcA, SrcB[1:0], Op[2:0], PCSrc[1:0], illegal
  logic [15:0] out_vec;
  assign out_vec = {enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF,
                    Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_ALU_Src_B,
                    Selector_ALU_Op, Selector_PC_Source, illegal_op};

  localparam logic [15:0] V_ZERO    = 16'h0000;
  localparam logic [15:0] V_FETCH   = {8'b1001_0000, 2'b01, 3'b001, 2'b00, 1'b0};
  localparam logic [15:0] V_DECODE  = {8'b0000_0000, 2'b11, 3'b001, 2'b00, 1'b0};
  localparam logic [15:0] V_DEC_ILL = {8'b0000_0000, 2'b11, 3'b001, 2'b00, 1'b1};
  localparam logic [15:0] V_IMMADD  = {8'b0000_0001, 2'b10, 3'b001, 2'b00, 1'b0};
  localparam logic [15:0] V_MEMRD   = {8'b0100_0000, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [15:0] V_MEMWB   = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [15:0] V_MEMWR   = {8'b0110_0000, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [15:0] V_RWB     = {8'b0000_1100, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [15:0] V_ADDIWB  = {8'b0000_1000, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [15:0] V_BR_T    = {8'b1000_0001, 2'b00, 3'b010, 2'b01, 1'b0};
  localparam logic [15:0] V_BR_NT   = {8'b0000_0001, 2'b00, 3'b010, 2'b01, 1'b0};
  localparam logic [15:0] V_JUMP    = {8'b1000_0000, 2'b00, 3'b000, 2'b10, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then move on to the next falling edge
  task automatic expect_cycle(input string tag, input logic [15:0] exp);
    #1;
    check_eq(tag, out_vec, exp);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  // R-type functs with their ALU op, checked through a full 4-cycle instruction
  logic [5:0] r_funct [5];
  logic [2:0] r_op    [5];

  initial begin
    checks = 0;
    errors = 0;
    r_funct[0] = 6'b100000; r_op[0] = 3'b001;
    r_funct[1] = 6'b100010; r_op[1] = 3'b010;
    r_funct[2] = 6'b100100; r_op[2] = 3'b000;
    r_funct[3] = 6'b100101; r_op[3] = 3'b011;
    r_funct[4] = 6'b101010; r_op[4] = 3'b100;
    reset = 1'b1;
    set_instr(6'b000000, 6'b100000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    expect_cycle("reset_outputs", V_ZERO);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      set_instr(6'b000000, r_funct[i], 1'b0);
      expect_cycle($sformatf("r%0d_fetch", i), V_FETCH);
      expect_cycle($sformatf("r%0d_decode", i), V_DECODE);
      expect_cycle($sformatf("r%0d_ex", i), {8'b0000_0001, 2'b00, r_op[i], 2'b00, 1'b0});
      expect_cycle($sformatf("r%0d_wb", i), V_RWB);
    end

    set_instr(6'b100011, 6'b000000, 1'b0);
    expect_cycle("lw_fetch", V_FETCH);
    expect_cycle("lw_decode", V_DECODE);
    expect_cycle("lw_memadr", V_IMMADD);
    expect_cycle("lw_memrd", V_MEMRD);
    expect_cycle("lw_memwb", V_MEMWB);

    set_instr(6'b101011, 6'b000000, 1'b0);
    expect_cycle("sw_fetch", V_FETCH);
    expect_cycle("sw_decode", V_DECODE);
    expect_cycle("sw_memadr", V_IMMADD);
    expect_cycle("sw_memwr", V_MEMWR);

    set_instr(6'b001000, 6'b000000, 1'b0);
    expect_cycle("addi_fetch", V_FETCH);
    expect_cycle("addi_decode", V_DECODE);
    expect_cycle("addi_ex", V_IMMADD);
    expect_cycle("addi_wb", V_ADDIWB);

    set_instr(6'b000100, 6'b000000, 1'b1);
    expect_cycle("beq_t_fetch", V_FETCH);
    expect_cycle("beq_t_decode", V_DECODE);
    expect_cycle("beq_taken", V_BR_T);

    set_instr(6'b000100, 6'b000000, 1'b0);
    expect_cycle("beq_nt_fetch", V_FETCH);
    expect_cycle("beq_nt_decode", V_DECODE);
    expect_cycle("beq_not_taken", V_BR_NT);

    set_instr(6'b000010, 6'b000000, 1'b0);
    expect_cycle("j_fetch", V_FETCH);
    expect_cycle("j_decode", V_DECODE);
    expect_cycle("j_jump", V_JUMP);

    set_instr(6'b111111, 6'b100000, 1'b0);
    expect_cycle("ill_op_fetch", V_FETCH);
    expect_cycle("ill_op_decode", V_DEC_ILL);

    set_instr(6'b000000, 6'b000000, 1'b0);
    expect_cycle("ill_fn_fetch", V_FETCH);
    expect_cycle("ill_fn_decode", V_DEC_ILL);

    set_instr(6'b000101, 6'b000000, 1'b0);
    expect_cycle("bne_fetch", V_FETCH);
`ifdef CU_BNE_EN
    expect_cycle("bne_decode", V_DECODE);
    expect_cycle("bne_taken", V_BR_T);
    set_instr(6'b000101, 6'b000000, 1'b1);
    expect_cycle("bne_nt_fetch", V_FETCH);
    expect_cycle("bne_nt_decode", V_DECODE);
    expect_cycle("bne_not_taken", V_BR_NT);
`else
    expect_cycle("bne_illegal", V_DEC_ILL);
`endif

    set_instr(6'b100011, 6'b000000, 1'b0);
    expect_cycle("rst_lw_fetch", V_FETCH);
    expect_cycle("rst_lw_decode", V_DECODE);
    expect_cycle("rst_lw_memadr", V_IMMADD);
    expect_cycle("rst_lw_memrd", V_MEMRD);
    reset = 1'b1;
    expect_cycle("rst_in_memwb", V_ZERO);
    reset = 1'b0;
    expect_cycle("rst_back_fetch", V_FETCH);
    expect_cycle("rst_then_decode", V_DECODE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
